// File: rtl/ahb_pkg.sv
// Shared AHB-lite encodings, slave FSM state type and byte-lane helper.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } ahb_state_e;

    // Little-endian lane enables for a legal (aligned, size <= word) access.
    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] lsb);
        case (size)
            HSIZE_BYTE: byte_en = 4'b0001 << lsb;
            HSIZE_HALF: byte_en = lsb[1] ? 4'b1100 : 4'b0011;
            default:    byte_en = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ahb_ram_be.sv
// Word-organised RAM with per-byte write enables and an asynchronous read port.
// Contents are never reset.
module ahb_ram_be #(
    parameter int WORDS = 256,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-lite memory slave with configurable wait states and two-cycle ERROR response.
//   state   | meaning
//   ST_IDLE | ready; completes a pending OKAY data phase, accepts address phases
//   ST_WAIT | OKAY data phase stretched, wait counter running down
//   ST_ERR1 | first ERROR cycle, HREADYOUT low
//   ST_ERR2 | second ERROR cycle, HREADYOUT high, next address phase accepted
module ahb_slave_mem
    import ahb_pkg::*;
#(
    parameter int unsigned MEM_WORDS   = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam int AW = $clog2(MEM_WORDS);

    ahb_state_e    state_q, state_d;
    logic [3:0]    wait_cnt_q, wait_cnt_d;
    logic          pend_q, pend_d;
    logic          write_q, write_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [3:0]    be_q, be_d;

    logic [31:0] addr_off;
    logic        size_err, align_err, range_err, xfer_err;
    logic        ready_out, accept;
    logic        ram_we;
    logic [31:0] ram_rdata;
    logic        unused_ok;

    assign addr_off  = HADDR - BASE_ADDR;
    assign size_err  = HSIZE > HSIZE_WORD;
    assign align_err = (HSIZE == HSIZE_HALF && HADDR[0]) ||
                       (HSIZE == HSIZE_WORD && HADDR[1:0] != 2'b00);
    // Unsigned compare on the full offset also rejects addresses below BASE_ADDR.
    assign range_err = {2'b00, addr_off[31:2]} >= 32'(MEM_WORDS);
    assign xfer_err  = size_err || align_err || range_err;

    assign ready_out = (state_q == ST_IDLE) || (state_q == ST_ERR2);
    assign accept    = HSEL && HREADY && ready_out &&
                       !(HTRANS == HTRANS_IDLE || HTRANS == HTRANS_BUSY);

    assign unused_ok = ^{HBURST, addr_off[1:0]};

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        pend_d     = pend_q;
        write_d    = write_q;
        idx_d      = idx_q;
        be_d       = be_q;
        case (state_q)
            ST_IDLE, ST_ERR2: begin
                state_d = ST_IDLE;
                pend_d  = 1'b0;
                if (accept) begin
                    if (xfer_err) begin
                        state_d = ST_ERR1;
                    end else begin
                        pend_d  = 1'b1;
                        write_d = HWRITE;
                        idx_d   = addr_off[AW+1:2];
                        be_d    = byte_en(HSIZE, HADDR[1:0]);
                        if (WAIT_STATES > 0) begin
                            state_d    = ST_WAIT;
                            wait_cnt_d = 4'(WAIT_STATES);
                        end
                    end
                end
            end
            ST_WAIT: begin
                wait_cnt_d = (wait_cnt_q == 4'd0) ? 4'd0 : wait_cnt_q - 4'd1;
                if (wait_cnt_q <= 4'd1) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 4'd0;
            pend_q     <= 1'b0;
            write_q    <= 1'b0;
            idx_q      <= '0;
            be_q       <= 4'b0000;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            pend_q     <= pend_d;
            write_q    <= write_d;
            idx_q      <= idx_d;
            be_q       <= be_d;
        end
    end

    // A write commits on the edge that ends its OKAY data phase, unless reset is asserted there.
    assign ram_we = HRESETn && pend_q && write_q && (state_q == ST_IDLE);

    ahb_ram_be #(
        .WORDS (MEM_WORDS),
        .AW    (AW)
    ) u_ram (
        .clk   (HCLK),
        .we    (ram_we),
        .addr  (idx_q),
        .be    (be_q),
        .wdata (HWDATA),
        .rdata (ram_rdata)
    );

    assign HREADYOUT = ready_out;
    assign HRESP     = (state_q == ST_ERR1 || state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    assign HRDATA    = (pend_q && !write_q && (state_q == ST_IDLE || state_q == ST_WAIT)) ?
                       ram_rdata : 32'h0;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Random and directed AHB-lite traffic against two slave instances (0 and 3 wait states),
// checked against a byte-level memory model.
module tb_ahb_slave_mem;

    localparam logic [31:0] BASE0  = 32'h0000_0000;
    localparam logic [31:0] BASE1  = 32'h0000_1000;
    localparam int unsigned WORDS0 = 64;
    localparam int unsigned WORDS1 = 32;
    localparam int unsigned WS0    = 0;
    localparam int unsigned WS1    = 3;

    typedef struct packed {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp;
    } tr_t;

    logic        clk = 1'b0;
    logic        hresetn;
    logic        hsel;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic [31:0] hrdata0, hrdata1;
    logic        hro0, hro1, hresp0, hresp1;
    logic        dsel;
    logic        hsel0, hsel1;

    int          n_chk = 0;
    int          n_err = 0;
    tr_t         q[$];
    logic [31:0] mdl [2][64];

    assign hsel0 = hsel && !dsel;
    assign hsel1 = hsel && dsel;

    always #5 clk = ~clk;

    ahb_slave_mem #(.MEM_WORDS(WORDS0), .BASE_ADDR(BASE0), .WAIT_STATES(WS0)) u_dut0 (
        .HCLK(clk), .HRESETn(hresetn), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hro0),
        .HRDATA(hrdata0), .HREADYOUT(hro0), .HRESP(hresp0));

    ahb_slave_mem #(.MEM_WORDS(WORDS1), .BASE_ADDR(BASE1), .WAIT_STATES(WS1)) u_dut1 (
        .HCLK(clk), .HRESETn(hresetn), .HSEL(hsel1), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HREADY(hro1),
        .HRDATA(hrdata1), .HREADYOUT(hro1), .HRESP(hresp1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] base_of();
        return dsel ? BASE1 : BASE0;
    endfunction

    function automatic int unsigned words_of();
        return dsel ? WORDS1 : WORDS0;
    endfunction

    function automatic int unsigned ws_of();
        return dsel ? WS1 : WS0;
    endfunction

    function automatic bit is_err(input tr_t t);
        logic [31:0] off;
        off = t.addr - base_of();
        if (t.size > 3'd2) return 1'b1;
        if ((t.addr % (32'd1 << t.size)) != 32'd0) return 1'b1;
        return (off / 32'd4) >= 32'(words_of());
    endfunction

    function automatic int unsigned widx(input logic [31:0] addr);
        logic [31:0] off;
        off = (addr - base_of()) / 32'd4;
        return off;
    endfunction

    task automatic model_write(input tr_t t);
        int unsigned lo, n, w;
        lo = t.addr % 4;
        n  = 1 << t.size;
        w  = widx(t.addr);
        for (int b = 0; b < 4; b++) begin
            if (b >= lo && b < lo + n) mdl[dsel][w][b*8 +: 8] = t.wdata[b*8 +: 8];
        end
    endtask

    function automatic tr_t mk(input logic wr, input logic [2:0] size, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic chk, input logic [31:0] exp);
        tr_t t;
        t.sel = 1'b1; t.trans = 2'b10; t.wr = wr; t.size = size;
        t.addr = addr; t.wdata = wdata; t.chk = chk; t.exp = exp;
        return t;
    endfunction

    function automatic tr_t rand_tr();
        tr_t t;
        int unsigned r, w, lo;
        r = $urandom_range(19);
        t.sel   = (r != 0);
        t.trans = (r == 1) ? 2'b00 : (r == 2) ? 2'b01 : ($urandom_range(1) != 0 ? 2'b11 : 2'b10);
        t.wr    = ($urandom_range(1) != 0);
        t.size  = ($urandom_range(15) == 0) ? 3'd3 : 3'($urandom_range(2));
        w  = ($urandom_range(9) == 0) ? words_of() + $urandom_range(3) : $urandom_range(words_of() - 1);
        lo = (t.size == 3'd0) ? $urandom_range(3) : (t.size == 3'd1) ? 2 * $urandom_range(1) : 0;
        if ($urandom_range(11) == 0) lo = $urandom_range(3);
        t.addr = base_of() + w * 4 + lo;
        if (dsel && $urandom_range(15) == 0) t.addr = base_of() - 4 * $urandom_range(1, 8);
        t.wdata = $urandom();
        t.chk   = 1'b0;
        t.exp   = 32'h0;
        return t;
    endfunction

    task automatic drive_idle();
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0; haddr = 32'h0; hburst = 3'd0;
    endtask

    // Plays q as a pipelined master; entered and left just after a rising edge.
    task automatic run_q(input int budget);
        tr_t         dp;
        bit          dp_on, exp_err, rdy, resp;
        logic [31:0] rd;
        int          lows, cyc, idx;
        dp_on = 0; lows = 0; cyc = 0; idx = 0; dp = '0;
        while ((idx < q.size() || dp_on) && cyc < budget) begin
            if (idx < q.size()) begin
                hsel = q[idx].sel; htrans = q[idx].trans; hwrite = q[idx].wr;
                hsize = q[idx].size; haddr = q[idx].addr; hburst = 3'($urandom_range(7));
            end else begin
                drive_idle();
            end
            hwdata = dp_on ? dp.wdata : 32'h0;
            @(negedge clk);
            rdy  = dsel ? hro1 : hro0;
            resp = dsel ? hresp1 : hresp0;
            rd   = dsel ? hrdata1 : hrdata0;
            if (dp_on) begin
                exp_err = is_err(dp);
                if (!rdy) begin
                    lows++;
                    check("wait_resp", 32'(resp), 32'(exp_err));
                end else begin
                    check("resp", 32'(resp), 32'(exp_err));
                    check("low_cycles", 32'(lows), exp_err ? 32'd1 : 32'(ws_of()));
                    if (!exp_err && !dp.wr) begin
                        check("rdata", rd, mdl[dsel][widx(dp.addr)]);
                        if (dp.chk) check("rdata_directed", rd, dp.exp);
                    end else begin
                        check("rdata_zero", rd, 32'h0);
                    end
                    if (!exp_err && dp.wr) model_write(dp);
                    dp_on = 0;
                end
            end else begin
                check("idle_ready", 32'(rdy), 32'd1);
                check("idle_resp", 32'(resp), 32'd0);
                check("idle_rdata", rd, 32'h0);
            end
            if (idx < q.size() && rdy) begin
                if (q[idx].sel && q[idx].trans[1]) begin
                    dp = q[idx]; dp_on = 1; lows = 0;
                end
                idx++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= budget) check("run_timeout", 32'(idx), 32'(q.size()));
        drive_idle();
        hwdata = 32'h0;
        q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] saved;
        hresetn = 1'b0; dsel = 1'b0; hwdata = 32'h0;
        drive_idle();
        repeat (3) @(posedge clk);
        #1 hresetn = 1'b1;
        @(negedge clk);
        check("reset_ready0", 32'(hro0), 32'd1);
        check("reset_resp0", 32'(hresp0), 32'd0);
        check("reset_rdata0", hrdata0, 32'h0);
        check("reset_ready1", 32'(hro1), 32'd1);
        check("reset_resp1", 32'(hresp1), 32'd0);
        check("reset_rdata1", hrdata1, 32'h0);
        @(posedge clk); #1;

        for (int d = 0; d < 2; d++) begin
            dsel = d[0];
            for (int w = 0; w < int'(words_of()); w++)
                q.push_back(mk(1'b1, 3'd2, base_of() + 32'(4 * w), $urandom(), 1'b0, 32'h0));
            run_q(1000);
        end

        dsel = 1'b0;
        q.push_back(mk(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0));
        q.push_back(mk(1'b0, 3'd2, 32'h10, 32'h0, 1'b1, 32'hDEAD_BEEF));
        run_q(50);
        q.push_back(mk(1'b1, 3'd2, 32'h10, 32'h1122_3344, 1'b0, 32'h0));
        q.push_back(mk(1'b1, 3'd0, 32'h13, 32'hA500_0000, 1'b0, 32'h0));
        q.push_back(mk(1'b0, 3'd2, 32'h10, 32'h0, 1'b1, 32'hA522_3344));
        run_q(50);
        saved = mdl[0][0];
        q.push_back(mk(1'b0, 3'd2, BASE0 + 4 * WORDS0, 32'h0, 1'b0, 32'h0));
        q.push_back(mk(1'b1, 3'd1, 32'h01, 32'hFFFF_FFFF, 1'b0, 32'h0));
        q.push_back(mk(1'b0, 3'd2, 32'h00, 32'h0, 1'b1, saved));
        run_q(50);

        dsel = 1'b1;
        q.push_back(mk(1'b0, 3'd2, BASE1 + 4 * WORDS1, 32'h0, 1'b0, 32'h0));
        q.push_back(mk(1'b0, 3'd2, BASE1 + 32'h4, 32'h0, 1'b0, 32'h0));
        run_q(50);

        saved = mdl[1][2];
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2; haddr = BASE1 + 32'h8;
        @(negedge clk);
        check("rst_write_accept", 32'(hro1), 32'd1);
        @(posedge clk); #1;
        drive_idle();
        hwdata = 32'hCAFE_F00D;
        @(negedge clk);
        check("rst_in_wait", 32'(hro1), 32'd0);
        hresetn = 1'b0;
        @(posedge clk); #1;
        hresetn = 1'b1;
        hwdata = 32'h0;
        @(negedge clk);
        check("rst_ready", 32'(hro1), 32'd1);
        check("rst_resp", 32'(hresp1), 32'd0);
        check("rst_rdata", hrdata1, 32'h0);
        @(posedge clk); #1;
        q.push_back(mk(1'b0, 3'd2, BASE1 + 32'h8, 32'h0, 1'b1, saved));
        run_q(50);

        for (int d = 0; d < 2; d++) begin
            dsel = d[0];
            repeat (300) q.push_back(rand_tr());
            run_q(3000);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
